alu: RTL and testbench

- 32-bit integer ALU for the execute stage of the pipelined CPU.
- Combinational operation decode feeds a single output register stage, so results and flags reach the EX/MEM boundary one cycle after the operands.
- Produces the result plus zero, carry and signed-overflow flags for branch and condition logic.

---
 rtl/alu_pkg.sv | 22 ++
 rtl/alu_if.sv | 28 ++
 rtl/alu_core.sv | 60 ++++++
 rtl/alu.sv | 50 +++++
 tb/tb_alu.sv | 194 +++++++++++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
// alu_pkg: shared definitions for the execute-stage ALU.
//   ALU_WIDTH - default datapath width
//   alu_op_e  - 4-bit operation encodings carried on funct3
package alu_pkg;

  localparam int ALU_WIDTH = 32;

  typedef enum logic [3:0] {
    ALU_ADD   = 4'd0,
    ALU_SUB   = 4'd1,
    ALU_AND   = 4'd2,
    ALU_OR    = 4'd3,
    ALU_XOR   = 4'd4,
    ALU_SLL   = 4'd5,
    ALU_SRL   = 4'd6,
    ALU_SRA   = 4'd7,
    ALU_SLT   = 4'd8,
    ALU_SLTU  = 4'd9,
    ALU_PASSB = 4'd10
  } alu_op_e;

endpackage

// File: rtl/alu_if.sv
// alu_if: operand/result bundle between the issue logic and the ALU.
//   a, b, funct3      - operands and operation select (master drives)
//   alu_out, z, c, v  - registered result and flags (slave drives)
// Handshake: none. The ALU accepts a new operation on every rising clock
// edge and presents its result one edge later; there is no valid/ready pair.
interface alu_if #(
  parameter int WIDTH = alu_pkg::ALU_WIDTH
);

  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [3:0]       funct3;
  logic             z;
  logic             c;
  logic             v;
  logic [WIDTH-1:0] alu_out;

  modport master (
    output a, b, funct3,
    input  z, c, v, alu_out
  );

  modport slave (
    input  a, b, funct3,
    output z, c, v, alu_out
  );

endinterface

// File: rtl/alu_core.sv
// alu_core: purely combinational compute of result, carry and overflow.
//   a, b    - operands; b[$clog2(WIDTH)-1:0] is the shift amount
//   funct3  - operation select (alu_op_e)
//   result  - operation result
//   c, v    - carry and signed overflow (only ADD/SUB set them)
module alu_core
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       funct3,
  output logic [WIDTH-1:0] result,
  output logic             c,
  output logic             v
);

  localparam int SHW = $clog2(WIDTH);

  logic [SHW-1:0] shamt;
  logic [WIDTH:0] add_sum;
  logic [WIDTH:0] sub_sum;

  assign shamt = b[SHW-1:0];

  // One extra bit on each sum holds the carry out. SUB is a + ~b + 1, so its
  // carry out is 1 exactly when no borrow occurs (a >= b unsigned).
  assign add_sum = {1'b0, a} + {1'b0, b};
  assign sub_sum = {1'b0, a} + {1'b0, ~b} + {{WIDTH{1'b0}}, 1'b1};

  always_comb begin
    result = '0;
    c      = 1'b0;
    v      = 1'b0;
    case (funct3)
      ALU_ADD: begin
        result = add_sum[WIDTH-1:0];
        c      = add_sum[WIDTH];
        v      = (a[WIDTH-1] == b[WIDTH-1]) && (add_sum[WIDTH-1] != a[WIDTH-1]);
      end
      ALU_SUB: begin
        result = sub_sum[WIDTH-1:0];
        c      = sub_sum[WIDTH];
        v      = (a[WIDTH-1] != b[WIDTH-1]) && (sub_sum[WIDTH-1] != a[WIDTH-1]);
      end
      ALU_AND:   result = a & b;
      ALU_OR:    result = a | b;
      ALU_XOR:   result = a ^ b;
      ALU_SLL:   result = a << shamt;
      ALU_SRL:   result = a >> shamt;
      ALU_SRA:   result = $unsigned($signed(a) >>> shamt);
      ALU_SLT:   result = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      ALU_SLTU:  result = {{(WIDTH-1){1'b0}}, (a < b)};
      ALU_PASSB: result = b;
      default:   result = '0;
    endcase
  end

endmodule

// File: rtl/alu.sv
// alu: 32-bit execute-stage ALU with a single output register stage.
//   clk    - rising-edge clock
//   rst_n  - asynchronous active-low reset, clears result and flags
//   bus    - alu_if slave: a, b, funct3 in; alu_out, z, c, v out
// Results and flags appear one clock after the operands are presented.
module alu
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH
) (
  input  logic  clk,
  input  logic  rst_n,
  alu_if.slave  bus
);

  logic [WIDTH-1:0] core_result;
  logic             core_c;
  logic             core_v;
  logic             core_z;

  alu_core #(
    .WIDTH (WIDTH)
  ) u_core (
    .a      (bus.a),
    .b      (bus.b),
    .funct3 (bus.funct3),
    .result (core_result),
    .c      (core_c),
    .v      (core_v)
  );

  // Zero is taken from the value about to be registered, so z always
  // describes the alu_out it is presented alongside.
  assign core_z = (core_result == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.alu_out <= '0;
      bus.z       <= 1'b0;
      bus.c       <= 1'b0;
      bus.v       <= 1'b0;
    end else begin
      bus.alu_out <= core_result;
      bus.z       <= core_z;
      bus.c       <= core_c;
      bus.v       <= core_v;
    end
  end

endmodule

// File: tb/tb_alu.sv
// tb_alu: self-checking bench for alu. Expected {z,c,v,alu_out} words are
// pushed when an operation is driven and popped one clock later.
module tb_alu;
  import alu_pkg::*;

  localparam int W = 32;
  localparam int EW = W + 3;

  logic clk;
  logic rst_n;

  int total;
  int bad;

  logic [EW-1:0] exp_q[$];

  alu_if #(.WIDTH(W)) bus ();

  alu #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [EW-1:0] got,
                       input logic [EW-1:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got z=%b c=%b v=%b out=%08h, want z=%b c=%b v=%b out=%08h",
               tag, got[EW-1], got[EW-2], got[EW-3], got[W-1:0],
               exp[EW-1], exp[EW-2], exp[EW-3], exp[W-1:0]);
    end
  endtask

  function automatic logic [EW-1:0] observed();
    return {bus.z, bus.c, bus.v, bus.alu_out};
  endfunction

  // Reference model written independently of the RTL structure: wide
  // integer arithmetic for flags, a bit-by-bit loop for arithmetic shift.
  function automatic logic [EW-1:0] model(input logic [W-1:0] a,
                                          input logic [W-1:0] b,
                                          input logic [3:0] f);
    logic [W-1:0]  out;
    logic          c;
    logic          v;
    logic [63:0]   s64;
    longint        sa;
    longint        sb;
    longint        ss;
    int            sh;
    out = '0;
    c   = 1'b0;
    v   = 1'b0;
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    sh  = int'(b[4:0]);
    case (f)
      4'd0: begin
        s64 = {32'b0, a} + {32'b0, b};
        out = s64[31:0];
        c   = s64[32];
        ss  = sa + sb;
        v   = (ss > 64'sd2147483647) || (ss < -64'sd2147483648);
      end
      4'd1: begin
        out = a - b;
        c   = (a >= b);
        ss  = sa - sb;
        v   = (ss > 64'sd2147483647) || (ss < -64'sd2147483648);
      end
      4'd2: out = a & b;
      4'd3: out = a | b;
      4'd4: out = a ^ b;
      4'd5: out = a << sh;
      4'd6: out = a >> sh;
      4'd7: begin
        out = a;
        for (int i = 0; i < sh; i++) out = {out[W-1], out[W-1:1]};
      end
      4'd8:  out = (sa < sb) ? 32'd1 : 32'd0;
      4'd9:  out = (a < b) ? 32'd1 : 32'd0;
      4'd10: out = b;
      default: out = '0;
    endcase
    return {(out == '0), c, v, out};
  endfunction

  // ---------------- driver ----------------
  task automatic drive_op(input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [3:0] f, input logic [EW-1:0] exp);
    @(negedge clk);
    bus.a      = a;
    bus.b      = b;
    bus.funct3 = f;
    exp_q.push_back(exp);
  endtask

  task automatic drive_rand(input logic [W-1:0] a, input logic [W-1:0] b,
                            input logic [3:0] f);
    drive_op(a, b, f, model(a, b, f));
  endtask

  // ---------------- monitor / scoreboard ----------------
  always @(posedge clk) begin
    #1;
    if (exp_q.size() > 0) begin
      logic [EW-1:0] e;
      e = exp_q.pop_front();
      check("op", observed(), e);
    end
  end

  // Builds {z,c,v,out} for directed expectations.
  function automatic logic [EW-1:0] ex(input logic z, input logic c,
                                       input logic v, input logic [W-1:0] o);
    return {z, c, v, o};
  endfunction

  // ---------------- stimulus ----------------
  initial begin
    total      = 0;
    bad        = 0;
    rst_n      = 1'b0;
    bus.a      = 32'd1;
    bus.b      = 32'd1;
    bus.funct3 = 4'd0;

    // Reset held across several edges with live inputs.
    repeat (3) @(posedge clk);
    #1;
    check("reset_hold", observed(), '0);

    @(negedge clk);
    rst_n = 1'b1;

    // Directed vectors; consecutive calls are back-to-back cycles.
    drive_op(32'h77359400, 32'h77359400, ALU_ADD,   ex(0, 0, 1, 32'hEE6B2800));
    drive_op(32'h77359400, 32'h77359400, ALU_SUB,   ex(1, 1, 0, 32'h00000000));
    drive_op(32'h00000000, 32'h00000001, ALU_SUB,   ex(0, 0, 0, 32'hFFFFFFFF));
    drive_op(32'h77359400, 32'h77359400, ALU_AND,   ex(0, 0, 0, 32'h77359400));
    drive_op(32'h77359400, 32'h77359400, ALU_OR,    ex(0, 0, 0, 32'h77359400));
    drive_op(32'h77359400, 32'h77359400, ALU_XOR,   ex(1, 0, 0, 32'h00000000));
    drive_op(32'h80000000, 32'h00000004, ALU_SLL,   ex(1, 0, 0, 32'h00000000));
    drive_op(32'h80000000, 32'h00000004, ALU_SRL,   ex(0, 0, 0, 32'h08000000));
    drive_op(32'h80000000, 32'h00000004, ALU_SRA,   ex(0, 0, 0, 32'hF8000000));
    drive_op(32'h77359400, 32'h77359400, ALU_SLL,   ex(0, 0, 0, 32'h77359400));
    drive_op(32'h77359400, 32'h77359400, ALU_SRL,   ex(0, 0, 0, 32'h77359400));
    drive_op(32'h00000001, 32'h00000124, ALU_SLL,   ex(0, 0, 0, 32'h00000010));
    drive_op(32'hFFFFFFFF, 32'h00000001, ALU_SLT,   ex(0, 0, 0, 32'h00000001));
    drive_op(32'hFFFFFFFF, 32'h00000001, ALU_SLTU,  ex(1, 0, 0, 32'h00000000));
    drive_op(32'hFFFFFFFF, 32'h00000001, ALU_PASSB, ex(0, 0, 0, 32'h00000001));
    drive_op(32'hFFFFFFFF, 32'h00000001, 4'd15,     ex(1, 0, 0, 32'h00000000));
    drive_op(32'hFFFFFFFF, 32'h00000001, ALU_ADD,   ex(1, 1, 0, 32'h00000000));
    drive_op(32'h80000000, 32'h00000001, ALU_SUB,   ex(0, 1, 1, 32'h7FFFFFFF));

    // Mid-stream asynchronous reset between edges.
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("reset_async", observed(), '0);
    @(negedge clk);
    rst_n = 1'b1;

    // Random back-to-back operations against the model.
    for (int i = 0; i < 40; i++) begin
      logic [W-1:0] ra;
      logic [W-1:0] rb;
      ra = $urandom();
      rb = $urandom();
      if (i % 8 == 3) rb = ra;
      if (i % 8 == 5) ra = 32'h80000000;
      if (i % 8 == 6) rb = $urandom_range(0, 31);
      drive_rand(ra, rb, 4'($urandom_range(0, 15)));
    end

    // Bounded drain of the scoreboard.
    for (int k = 0; k < 5 && exp_q.size() > 0; k++) @(posedge clk);
    @(posedge clk);
    #2;
    check("queue_drained", EW'(exp_q.size()), '0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
